decoder_onehot_pipe: RTL

DECODER_ONEHOT_PIPE -- requirements
Module: decoder_onehot_pipe

---
 rtl/decoder_pkg.sv | 57 +++++
 rtl/decoder_skid_buf.sv | 88 ++++++++
 rtl/decoder_onehot_pipe.sv | 52 +++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and the pure decode function for the one-hot decoder pipeline.
package decoder_pkg;

    // Widest decoded word the decode function can produce (IN_W tops out at 8).
    localparam int MAX_W = 256;

    // Decode mode, carried in with each input beat.
    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'd0,
        MODE_THERM   = 2'd1,
        MODE_ONECOLD = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Decode an index into an out_w-bit word.
    // Result layout: bit 0 is the range error, bits [out_w:1] are the word.
    // Bits above out_w are always zero, so callers narrow with a width cast.
    // An out-of-range index yields all zero for ONEHOT/THERM (THERM does not
    // saturate) and all ones for ONECOLD; enable=0 forces the word to zero
    // but the range error is still reported.
    function automatic logic [MAX_W:0] decode_word(
        input logic [7:0] idx,
        input mode_e      mode,
        input logic       enable,
        input int         out_w
    );
        logic [MAX_W-1:0] word;
        logic             err;
        int               pos;

        pos  = int'(idx);
        err  = (pos >= out_w);
        word = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < out_w) begin
                case (mode)
                    MODE_ONEHOT:  word[b] = (b == pos);
                    MODE_THERM:   word[b] = (b <= pos) && !err;
                    MODE_ONECOLD: word[b] = (b != pos);
                    default:      word[b] = 1'b0;
                endcase
            end
        end
        if (!enable) begin
            word = '0;
        end
        return {word, err};
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry skid buffer: an output register plus a skid register, with a
// registered in_ready that is high exactly when the skid register is empty.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    state_e        state_reg;
    state_e        state_next;
    logic [DW-1:0] out_data_reg;
    logic [DW-1:0] skid_data_reg;
    logic          out_valid_reg;
    logic          in_ready_reg;
    logic          accept;
    logic          consume;

    assign accept  = in_valid && in_ready_reg;
    assign consume = out_valid_reg && out_ready;

    // Next occupancy from the accept/consume pair of this cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !consume) begin
                    state_next = FULL;
                end else if (!accept && consume) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (consume) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // State, data movement and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            out_data_reg  <= '0;
            skid_data_reg <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next != EMPTY);
            in_ready_reg  <= (state_next != FULL);
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        out_data_reg <= in_data;
                    end
                end
                ONE: begin
                    // Accept with consume bypasses the skid register.
                    if (accept && consume) begin
                        out_data_reg <= in_data;
                    end else if (accept) begin
                        skid_data_reg <= in_data;
                    end
                end
                FULL: begin
                    if (consume) begin
                        out_data_reg <= skid_data_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Pipelined binary-to-word decoder: decodes each accepted beat into a
// one-hot / thermometer / one-cold word plus a range error, and buffers the
// result in a two-entry skid buffer with valid/ready handshakes on both sides.
module decoder_onehot_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  binary_in,
    input  logic [1:0]       mode,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] decoder_out,
    output logic             range_err
);

    logic [7:0]   idx;
    mode_e        mode_sel;
    logic [OUT_W:0] beat_in;
    logic [OUT_W:0] beat_out;

    assign idx      = 8'(binary_in);
    assign mode_sel = mode_e'(mode);

    // Decode at acceptance so the word and error travel with the beat;
    // bit 0 of the beat is the range error, the word sits above it.
    assign beat_in[0]       = 1'(decode_word(idx, mode_sel, enable, OUT_W));
    assign beat_in[OUT_W:1] = OUT_W'(decode_word(idx, mode_sel, enable, OUT_W) >> 1);

    decoder_skid_buf #(
        .DW(OUT_W + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (beat_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (beat_out)
    );

    assign range_err   = beat_out[0];
    assign decoder_out = beat_out[OUT_W:1];

endmodule
